crc_share_arb: RTL and testbench
================================

# crc_share_arb

Round-robin arbiter and sequencer that shares a single CRC-32 engine (`crc`: valid / data_raw / crc / done) among several packet parsers. It sits between up to NUM_REQ parser instances and one `crc` instance. It accepts one payload block at a time, issues it to the engine, waits for `done`, and returns the checksum to the granted requester only. This lets multi-port designs instantiate one CRC engine instead of one per parser.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 320, payload block width fed to the CRC engine
- TIMEOUT, 64, max WAIT cycles before abort (used only with CRC_ARB_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a block pending
- req_data  in  NUM_REQ*DATA_W  block of requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept; handshake on req_valid[i] && req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse to requester
- rsp_crc  out  32  result, valid when any rsp_valid bit is high
- rsp_err  out  1  result is a timeout abort (constant 0 without macro)
- crc_valid  out  1  one-cycle start pulse to engine
- crc_data  out  DATA_W  block to engine, held stable from crc_valid until done
- crc_result  in  32  engine checksum
- crc_done  in  1  engine completion pulse
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. 2-bit encoding; unreachable codes return to IDLE.
- Round-robin pointer `ptr` ($clog2(NUM_REQ) bits). Grant goes to the first i with req_valid[i], searching from ptr upward modulo NUM_REQ.
- IDLE:
  - If any req_valid, req_ready[grant] = 1. This is combinational and only valid in IDLE.
  - On that edge: latch grant index and req_data slice into crc_data, then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE: crc_valid = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On crc_done: capture crc_result into rsp_crc, then go to RESP.
  - crc_done is ignored in IDLE, ISSUE and RESP. A done pulse arriving in ISSUE is a protocol violation and is dropped.
- RESP:
  - rsp_valid[idx] = 1 for one cycle.
  - ptr <= (idx+1) mod NUM_REQ, with explicit wrap for non-power-of-2 NUM_REQ.
  - Go to IDLE.
- A requester may drop req_valid before it is granted; no side effects. req_data is sampled only at the accept edge.
- A requester that is re-requesting loses to any other pending requester, because ptr has advanced past it.
- Reset, including mid-operation:
  - Go to IDLE, ptr = 0.
  - All outputs go to 0: req_ready, rsp_valid, rsp_crc, rsp_err, crc_valid, crc_data, busy.
  - The in-flight block is discarded. A late crc_done is ignored.

## Timing
- Accept at edge 0, crc_valid high in cycle 1, WAIT from cycle 2.
- If crc_done is high in cycle k (k >= 2), rsp_valid and rsp_crc appear in cycle k+1, and IDLE follows in cycle k+2.
- The next accept is possible in cycle k+2 at the earliest. Throughput is one block per (engine latency + 3) cycles.
- rsp_valid, rsp_crc, rsp_err, crc_valid, crc_data and busy are registered. req_ready is combinational from state, ptr and req_valid.
- rsp_crc holds its value until the next capture.

## Configuration
- CRC_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT-1 without crc_done: go to RESP with rsp_crc = 32'hFFFF_FFFF and rsp_err = 1.
  - rsp_err otherwise pulses 0 alongside rsp_valid.
- CRC_ARB_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - rsp_err is tied to 0 and no counter is instantiated.

## Test plan
- Single requester 0 sends a block, engine returns 32'hCBF43926 after 3 cycles: req_ready[0] at cycle 0, crc_valid at cycle 1, rsp_valid = 4'b0001 with rsp_crc = 32'hCBF43926 at cycle 5.
- All four req_valid held high after reset: grants in order 0, 1, 2, 3, 0. Each rsp_valid pulse matches its own requester's data.
- Requesters 1 and 3 pending with ptr = 2: requester 3 is granted first, then ptr wraps to 0 and requester 1 is granted.
- rst asserted in WAIT, then crc_done pulses one cycle after release: no rsp_valid, all outputs 0, next grant goes to requester 0.
- With CRC_ARB_TIMEOUT_EN and TIMEOUT = 8, engine never signals done: rsp_valid after 8 WAIT cycles with rsp_crc = 32'hFFFFFFFF and rsp_err = 1. Without the macro, busy stays high indefinitely.
- crc_done injected during ISSUE and during IDLE: ignored. The result is taken only from the done pulse in WAIT.

Source files
------------

// File: rtl/crc_share_arb.sv
// Round-robin arbiter sharing one CRC-32 engine among NUM_REQ requesters.
// Optional WAIT timeout abort is enabled by defining CRC_ARB_TIMEOUT_EN.
module crc_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 320,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_crc,
  output logic                      rsp_err,
  output logic                      crc_valid,
  output logic [DATA_W-1:0]         crc_data,
  input  logic [31:0]               crc_result,
  input  logic                      crc_done,
  output logic                      busy
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [PtrW:0] NReq = (PtrW+1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 256) begin : g_param_check
    $error("crc_share_arb: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle = 2'd0, StIssue = 2'd1, StWait = 2'd2, StResp = 2'd3} state_e;

  state_e          state;
  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] idx;
  logic [PtrW-1:0] grant;
  logic            grant_any;
  logic [PtrW:0]   cand;

  // First pending requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (PtrW+1)'(off);
      if (cand >= NReq) cand = cand - NReq;
      if (!grant_any && req_valid[cand[PtrW-1:0]]) begin
        grant_any = 1'b1;
        grant     = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == StIdle && grant_any) req_ready[grant] = 1'b1;
  end

`ifdef CRC_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= '0;
      idx       <= '0;
      rsp_valid <= '0;
      rsp_crc   <= '0;
      crc_valid <= 1'b0;
      crc_data  <= '0;
      busy      <= 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      crc_valid <= 1'b0;
      rsp_valid <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (grant_any) begin
            idx       <= grant;
            crc_data  <= req_data[DATA_W*32'(grant) +: DATA_W];
            crc_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          state <= StWait;
`ifdef CRC_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        StWait: begin
          if (crc_done) begin
            rsp_crc        <= crc_result;
            rsp_valid[idx] <= 1'b1;
            state          <= StResp;
          end
`ifdef CRC_ARB_TIMEOUT_EN
          else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            rsp_crc        <= 32'hFFFF_FFFF;
            err_q          <= 1'b1;
            rsp_valid[idx] <= 1'b1;
            state          <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        StResp: begin
          ptr   <= (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_share_arb.sv
// Self-checking bench for crc_share_arb: randomized traffic against a round-robin model.
// Timeout checks follow CRC_ARB_TIMEOUT_EN when it is defined for the build.
module tb_crc_share_arb;
  localparam int unsigned NumReq  = 4;
  localparam int unsigned DataW   = 320;
  localparam int unsigned Timeout = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NumReq-1:0]        req_valid = '0;
  logic [NumReq*DataW-1:0]  req_data = '0;
  logic [NumReq-1:0]        req_ready;
  logic [NumReq-1:0]        rsp_valid;
  logic [31:0]              rsp_crc;
  logic                     rsp_err;
  logic                     crc_valid;
  logic [DataW-1:0]         crc_data;
  logic [31:0]              crc_result = '0;
  logic                     crc_done = 1'b0;
  logic                     busy;

  int          errors = 0;
  int          checks = 0;
  int          m_ptr  = 0;
  logic [31:0] m_crc  = '0;

  // Observations recorded by drive_txn
  logic [NumReq-1:0] o_ready, o_rv, o_rresp;
  logic              o_cv, o_re, o_idle;
  logic [DataW-1:0]  o_cd, o_cd_late;
  logic [31:0]       o_rc;

  crc_share_arb #(.NUM_REQ(NumReq), .DATA_W(DataW), .TIMEOUT(Timeout)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_crc(rsp_crc), .rsp_err(rsp_err), .crc_valid(crc_valid),
    .crc_data(crc_data), .crc_result(crc_result), .crc_done(crc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < NumReq * DataW / 32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; crc_done = 1'b0;
    step(); step();
    rst = 1'b0;
    m_ptr = 0; m_crc = '0;
  endtask

  function automatic int model_grant(input logic [NumReq-1:0] pend);
    for (int off = 0; off < NumReq; off++)
      if (pend[(m_ptr + off) % NumReq]) return (m_ptr + off) % NumReq;
    return -1;
  endfunction

  // One complete transaction with fixed timing; records outputs, compares nothing.
  task automatic drive_txn(input logic [NumReq-1:0] pend, input int lat, input logic [31:0] res);
    req_valid = pend;
    #1 o_ready = req_ready;
    step();
    o_cv = crc_valid; o_cd = crc_data;
    scramble();
    step();
    repeat (lat) step();
    crc_done = 1'b1; crc_result = res; o_cd_late = crc_data;
    step();
    crc_done = 1'b0; crc_result = $urandom;
    o_rv = rsp_valid; o_rc = rsp_crc; o_re = rsp_err; o_rresp = req_ready;
    step();
    o_idle = !busy && rsp_valid == '0 && !crc_valid;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, crc_valid, rsp_valid, rsp_err, rsp_crc, req_ready} !== '0 || crc_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b cv=%b rv=%b err=%b crc=%h rdy=%b data_nz=%b", busy,
               crc_valid, rsp_valid, rsp_err, rsp_crc, req_ready, crc_data != '0);
    end
  endtask

  task automatic test_single();
    logic [DataW-1:0] exp_d;
    scramble();
    exp_d = req_data[0 +: DataW];
    drive_txn(4'b0001, 2, 32'hCBF4_3926);
    req_valid = '0;
    checks++;
    if (o_ready !== 4'b0001 || o_cv !== 1'b1) begin
      errors++; $display("FAIL single_accept: ready=%b cv=%b, want 0001 1", o_ready, o_cv);
    end
    checks++;
    if (o_cd !== exp_d || o_cd_late !== exp_d) begin
      errors++; $display("FAIL single_data: crc_data %h / %h, want %h", o_cd, o_cd_late, exp_d);
    end
    checks++;
    if (o_rv !== 4'b0001 || o_rc !== 32'hCBF4_3926 || o_re !== 1'b0) begin
      errors++; $display("FAIL single_rsp: rv=%b crc=%h err=%b, want 0001 cbf43926 0",
                         o_rv, o_rc, o_re);
    end
    checks++;
    if (o_idle !== 1'b1 || rsp_crc !== 32'hCBF4_3926) begin
      errors++; $display("FAIL single_after: idle=%b crc=%h, want 1 cbf43926", o_idle, rsp_crc);
    end
    m_ptr = 1; m_crc = 32'hCBF4_3926;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [DataW-1:0] exp_d;
    logic [31:0] res;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      scramble();
      exp_d = req_data[exp_order[k]*DataW +: DataW];
      res = $urandom;
      drive_txn(4'b1111, k, res);
      checks++;
      if (o_ready !== 4'(1 << exp_order[k]) || o_rv !== 4'(1 << exp_order[k]) ||
          o_rresp !== '0) begin
        errors++; $display("FAIL rr_grant[%0d]: ready=%b rv=%b resp_ready=%b, want idx %0d",
                           k, o_ready, o_rv, o_rresp, exp_order[k]);
      end
      checks++;
      if (o_cd !== exp_d || o_rc !== res || o_idle !== 1'b1) begin
        errors++; $display("FAIL rr_data[%0d]: crc=%h want %h, data_ok=%b idle=%b", k, o_rc,
                           res, o_cd === exp_d, o_idle);
      end
      m_crc = res;
    end
    req_valid = '0;
    m_ptr = 1;
  endtask

  task automatic test_wrap();
    logic [NumReq-1:0] exp_seq[3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [NumReq-1:0] pend_seq[3] = '{4'b0010, 4'b1010, 4'b1010};
    logic [31:0] res;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      res = $urandom;
      drive_txn(pend_seq[k], 1, res);
      checks++;
      if (o_ready !== exp_seq[k] || o_rv !== exp_seq[k] || o_rc !== res) begin
        errors++; $display("FAIL wrap[%0d]: ready=%b rv=%b crc=%h, want %b %b %h", k, o_ready,
                           o_rv, o_rc, exp_seq[k], exp_seq[k], res);
      end
      m_crc = res;
    end
    req_valid = '0;
    m_ptr = 2;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    scramble();
    req_valid = 4'b0100;
    step(); step(); step();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, crc_valid, rsp_valid, rsp_err, rsp_crc, req_ready} !== '0 || crc_data !== '0) begin
      errors++; $display("FAIL midreset_outputs: busy=%b cv=%b rv=%b crc=%h data_nz=%b", busy,
                         crc_valid, rsp_valid, rsp_crc, crc_data != '0);
    end
    crc_done = 1'b1; crc_result = $urandom;
    step();
    crc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== '0 || busy !== 1'b0) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0 || rsp_crc !== '0) begin
      errors++; $display("FAIL midreset_late_done: bad cycles=%0d crc=%h, want 0 0", pulses,
                         rsp_crc);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_next_grant: ready=%b, want 0001", req_ready);
    end
    req_valid = '0;
    step();
    m_ptr = 0; m_crc = '0;
  endtask

  task automatic test_done_ignored();
    logic [NumReq-1:0] pend;
    logic [31:0] good;
    int g;
    crc_done = 1'b1; crc_result = 32'hDEAD_BEEF;
    step();
    crc_done = 1'b0;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || rsp_crc !== m_crc) begin
      errors++; $display("FAIL done_in_idle: rv=%b busy=%b crc=%h, want 0 0 %h", rsp_valid, busy,
                         rsp_crc, m_crc);
    end
    pend = 4'($urandom_range(1, 15));
    g = model_grant(pend);
    scramble();
    req_valid = pend;
    step();
    req_valid = '0;
    crc_done = 1'b1; crc_result = 32'hBAD0_BAD0;
    step();
    crc_done = 1'b0;
    step();
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL done_in_issue: rv=%b busy=%b, want 0 1", rsp_valid, busy);
    end
    good = $urandom;
    crc_done = 1'b1; crc_result = good;
    step();
    crc_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'(1 << g) || rsp_crc !== good) begin
      errors++; $display("FAIL done_in_wait: rv=%b crc=%h, want %b %h", rsp_valid, rsp_crc,
                         4'(1 << g), good);
    end
    step();
    m_ptr = (g + 1) % NumReq; m_crc = good;
  endtask

  task automatic test_timeout();
    int g;
    int pulses = 0;
    g = model_grant(4'b0001);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
`ifdef CRC_ARB_TIMEOUT_EN
    repeat (Timeout - 1) begin
      if (rsp_valid !== '0) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL timeout_early: early pulses=%0d, want 0", pulses);
    end
    step();
    checks++;
    if (rsp_valid !== 4'(1 << g) || rsp_crc !== 32'hFFFF_FFFF || rsp_err !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: rv=%b crc=%h err=%b, want %b ffffffff 1",
                         rsp_valid, rsp_crc, rsp_err, 4'(1 << g));
    end
    step();
    m_ptr = (g + 1) % NumReq; m_crc = 32'hFFFF_FFFF;
`else
    repeat (100) begin
      if (rsp_valid !== '0 || rsp_err !== 1'b0 || busy !== 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL no_timeout_hang: bad cycles=%0d busy=%b, want 0 1", pulses, busy);
    end
    do_reset();
`endif
  endtask

  task automatic test_random();
    logic [NumReq-1:0] pend;
    logic [DataW-1:0]  exp_d;
    logic [31:0]       res;
    int                g;
    for (int k = 0; k < 20; k++) begin
      pend = 4'($urandom_range(1, 15));
      g = model_grant(pend);
      scramble();
      exp_d = req_data[g*DataW +: DataW];
      res = $urandom;
      drive_txn(pend, int'($urandom_range(0, 6)), res);
      checks++;
      if ({o_ready, o_cv, o_rv, o_rc, o_re, o_rresp, o_idle} !==
          {4'(1 << g), 1'b1, 4'(1 << g), res, 1'b0, 4'b0000, 1'b1}) begin
        errors++; $display("FAIL rand_txn[%0d]: ready=%b cv=%b rv=%b crc=%h err=%b idle=%b, want idx %0d crc %h",
                           k, o_ready, o_cv, o_rv, o_rc, o_re, o_idle, g, res);
      end
      checks++;
      if (o_cd !== exp_d || o_cd_late !== exp_d) begin
        errors++; $display("FAIL rand_data[%0d]: crc_data mismatch for requester %0d", k, g);
      end
      m_ptr = (g + 1) % NumReq; m_crc = res;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_done_ignored();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
